en_pipe_driver: RTL and testbench
=================================

// Module: en_pipe_driver
// PURPOSE
//  Synthesizable initiator/checker for the en-gated 2-stage data pipeline (en/data in, data_out out).
//  Drives en/data in programmable bursts separated by idle gaps; consumes data_out and checks it
//  against a shadow model of the pipeline. Sits beside the pipeline DUT, on the opposite side of dut_if.
// PARAMETERS
//  DW    4     data width, matches pipeline data/data_out
//  SEED  4'hA  first data value after reset
//  STEP  1     data increment per en-active cycle, modulo 2**DW
//  CW    8     width of burst_len/gap_len/num_bursts counters
//  ECW   16    width of err_count and beats
// PORTS
//  clk         in   1    clock, all logic on posedge
//  rst_n       in   1    reset, synchronous, active-low
//  start       in   1    1-cycle pulse: begin a run; honoured only in IDLE or DONE
//  burst_len   in   CW   en-active cycles per burst, sampled at start; 0 treated as 1
//  gap_len     in   CW   en-low cycles between bursts, sampled at start; 0 = back-to-back bursts
//  num_bursts  in   CW   bursts per run, sampled at start; 0 = run completes immediately
//  en          out  1    pipeline enable
//  data        out  DW   pipeline data
//  data_out    in   DW   pipeline output under check
//  busy        out  1    high in BURST/GAP
//  done        out  1    high in DONE, cleared by start or reset
//  err         out  1    sticky mismatch flag, cleared only by reset
//  err_count   out  ECW  mismatch count, saturates at all-ones
//  beats       out  ECW  en-active cycles driven since reset, wraps
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; en=0, data=SEED, busy=0, done=0, err=0, err_count=0,
//   beats=0; shadow fill=0. Reset mid-run aborts immediately, no drain.
//  All outputs registered; en/data change only at posedge.
//  FSM: IDLE -start-> BURST (num_bursts>0) | DONE (num_bursts==0).
//   BURST: en=1 for max(burst_len,1) cycles; data advances by STEP after each en-active edge.
//   after last beat: more bursts left -> GAP if gap_len>0 else BURST; none left -> DONE.
//   GAP: en=0 for gap_len cycles, data held; -> BURST.
//   DONE: en=0; start -> BURST/DONE as from IDLE (new params sampled). start in BURST/GAP ignored.
//  data is continuous across bursts and runs; reset only via rst_n.
//  Shadow model: at each posedge with en=1: sh1<=data, sh2<=sh1, fill<=min(fill+1,2).
//   Pipeline has no reset: its output is defined only once fill==2.
//  Check: at each posedge where fill==2 (pre-edge), compare data_out with sh2 (pre-edge);
//   mismatch -> err<=1, err_count<=sat(err_count+1). Checking also runs in GAP/DONE/IDLE.
//  Expected latency: value driven on beat N appears on data_out after beat N+1's edge.
//  Shadow state survives start; pipeline contents persist across runs, so first beats of a new
//   run still check against the prior run's tail.
//  Simultaneous start and rst_n=0: reset wins.
// STRUCTURE
//  Package en_pipe_pkg: state enum {IDLE,BURST,GAP,DONE}, DW/CW/ECW defaults, sat_inc function.
//  Sub-module en_pipe_shadow: 2-stage shadow pipe, fill counter, comparator, err/err_count.
//  Top: FSM, burst/gap/burst-index counters, data generator, beats counter.
// TESTING
//  1 reset: rst_n=0 2 cycles -> en=0, data=A, err=0, err_count=0, done=0, busy=0.
//  2 burst_len=4,gap_len=2,num_bursts=2 into real pipeline -> en pattern 1111 00 1111,
//    data A,B,C,D,E,F,0,1; data_out shows A..F,0 with 1-beat lag; done=1; err_count=0; beats=8.
//  3 gap_len=0,burst_len=3,num_bursts=3 -> en high 9 consecutive cycles, no GAP visited.
//  4 fault inject: force data_out bit0 inverted for 3 checked cycles -> err=1, err_count=3, sticky.
//  5 boundaries: num_bursts=0 -> DONE next cycle, en never 1; burst_len=0 -> 1 beat per burst;
//    start while busy -> ignored, params unchanged.
//  6 rst_n=0 mid-burst -> next edge en=0, data=A, fill=0; no errors flagged during first 2 beats after.

Source files
------------

// File: rtl/en_pipe_pkg.sv
// rtl/en_pipe_pkg.sv - shared types, defaults and helpers for the en pipe driver
package en_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DW_DEF  = 4;
  localparam int CW_DEF  = 8;
  localparam int ECW_DEF = 16;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/en_pipe_driver_if.sv
// rtl/en_pipe_driver_if.sv - en/data/data_out bus between driver and pipeline
interface en_pipe_driver_if
  import en_pipe_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] data_out;

  modport master (output en, output data, input data_out);
  modport slave  (input en, input data, output data_out);
endinterface

// File: rtl/en_pipe_shadow.sv
// rtl/en_pipe_shadow.sv - shadow 2-stage pipe and data_out comparator
module en_pipe_shadow
  import en_pipe_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int ECW = ECW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [DW-1:0]  data,
  input  logic [DW-1:0]  data_out,
  output logic           err,
  output logic [ECW-1:0] err_count
);

  logic [DW-1:0]  sh1_q, sh1_d;
  logic [DW-1:0]  sh2_q, sh2_d;
  logic [1:0]     fill_q, fill_d;
  logic           err_q, err_d;
  logic [ECW-1:0] err_count_q, err_count_d;

  // Mirror the pipeline; compare only once both stages hold driven data.
  always_comb begin
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    fill_d      = fill_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    if (en) begin
      sh1_d  = data;
      sh2_d  = sh1_q;
      fill_d = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
    end
    if (fill_q == 2'd2 && data_out != sh2_q) begin
      err_d       = 1'b1;
      err_count_d = ECW'(sat_inc(32'(err_count_q), ECW));
    end
  end

  // Shadow state and error flags; reset is the only way to clear them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh1_q       <= '0;
      sh2_q       <= '0;
      fill_q      <= 2'd0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      fill_q      <= fill_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/en_pipe_driver.sv
// rtl/en_pipe_driver.sv - burst/gap stimulus generator and checker for the en pipeline
module en_pipe_driver
  import en_pipe_pkg::*;
#(
  parameter int            DW   = DW_DEF,
  parameter logic [DW-1:0] SEED = DW'(4'hA),
  parameter int            STEP = 1,
  parameter int            CW   = CW_DEF,
  parameter int            ECW  = ECW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CW-1:0]       burst_len,
  input  logic [CW-1:0]       gap_len,
  input  logic [CW-1:0]       num_bursts,
  en_pipe_driver_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ECW-1:0]      err_count,
  output logic [ECW-1:0]      beats
);

  state_e         state_q, state_d;
  logic [CW-1:0]  beat_left_q, beat_left_d;
  logic [CW-1:0]  gap_left_q, gap_left_d;
  logic [CW-1:0]  burst_left_q, burst_left_d;
  logic [CW-1:0]  blen_q, blen_d;
  logic [CW-1:0]  glen_q, glen_d;
  logic           en_q, en_d;
  logic [DW-1:0]  data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [ECW-1:0] beats_q, beats_d;
  logic [CW-1:0]  blen_eff;

  // Next-state logic; counters hold the beats/gaps/bursts remaining after the current cycle.
  always_comb begin
    state_d      = state_q;
    beat_left_d  = beat_left_q;
    gap_left_d   = gap_left_q;
    burst_left_d = burst_left_q;
    blen_d       = blen_q;
    glen_d       = glen_q;
    data_d       = data_q;
    beats_d      = beats_q;
    blen_eff     = (burst_len == '0) ? CW'(1) : burst_len;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          blen_d = blen_eff;
          glen_d = gap_len;
          if (num_bursts == '0) begin
            state_d = DONE;
          end else begin
            state_d      = BURST;
            beat_left_d  = blen_eff - CW'(1);
            burst_left_d = num_bursts - CW'(1);
          end
        end
      end
      BURST: begin
        if (beat_left_q != '0) begin
          beat_left_d = beat_left_q - CW'(1);
        end else if (burst_left_q != '0) begin
          burst_left_d = burst_left_q - CW'(1);
          if (glen_q != '0) begin
            state_d    = GAP;
            gap_left_d = glen_q - CW'(1);
          end else begin
            beat_left_d = blen_q - CW'(1);
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_left_q != '0) begin
          gap_left_d = gap_left_q - CW'(1);
        end else begin
          state_d     = BURST;
          beat_left_d = blen_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == BURST);
    busy_d = (state_d == BURST) || (state_d == GAP);
    done_d = (state_d == DONE);
    if (en_q) begin
      data_d  = data_q + DW'(STEP);
      beats_d = beats_q + ECW'(1);
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_left_q  <= '0;
      gap_left_q   <= '0;
      burst_left_q <= '0;
      blen_q       <= '0;
      glen_q       <= '0;
      en_q         <= 1'b0;
      data_q       <= SEED;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beats_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_left_q  <= beat_left_d;
      gap_left_q   <= gap_left_d;
      burst_left_q <= burst_left_d;
      blen_q       <= blen_d;
      glen_q       <= glen_d;
      en_q         <= en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beats_q      <= beats_d;
    end
  end

  en_pipe_shadow #(.DW(DW), .ECW(ECW)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_q),
    .data      (data_q),
    .data_out  (bus.data_out),
    .err       (err),
    .err_count (err_count)
  );

  assign bus.en   = en_q;
  assign bus.data = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign beats    = beats_q;

endmodule

// File: tb/tb_en_pipe_driver.sv
// tb/tb_en_pipe_driver.sv - directed self-checking bench for en_pipe_driver
module tb_en_pipe_driver;
  import en_pipe_pkg::*;

  localparam int DW  = 4;
  localparam int CW  = 8;
  localparam int ECW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [CW-1:0]  burst_len = '0;
  logic [CW-1:0]  gap_len = '0;
  logic [CW-1:0]  num_bursts = '0;
  logic           busy, done, err;
  logic [ECW-1:0] err_count, beats;
  logic [DW-1:0]  p1 = '0;
  logic [DW-1:0]  p2 = '0;
  logic           fault = 1'b0;
  int             n_checks = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  en_pipe_driver_if #(.DW(DW)) dif ();

  en_pipe_driver #(.DW(DW), .CW(CW), .ECW(ECW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .num_bursts (num_bursts),
    .bus        (dif.master),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_count  (err_count),
    .beats      (beats)
  );

  // Reference en-gated 2-stage pipeline, no reset; fault flips bit0 of its output.
  always @(posedge clk) begin
    if (dif.en) begin
      p1 <= dif.data;
      p2 <= p1;
    end
  end
  assign dif.data_out = p2 ^ {{(DW-1){1'b0}}, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [CW-1:0] bl, input logic [CW-1:0] gl, input logic [CW-1:0] nb);
    burst_len  = bl;
    gap_len    = gl;
    num_bursts = nb;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  bit         en_t2   [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  logic [3:0] data_t2 [11] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hE, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
  logic [3:0] dout_t2 [11] = '{4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hC, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
  bit         en_t5b  [4]  = '{1, 0, 1, 0};
  bit         en_t5c  [6]  = '{1, 1, 0, 1, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_en", 32'(dif.en), 32'h0);
    check_eq("rst_data", 32'(dif.data), 32'hA);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_err_count", 32'(err_count), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_beats", 32'(beats), 32'h0);
    rst_n = 1'b1;
    tick();

    // 2: two bursts of 4 with a 2-cycle gap
    kick(8'd4, 8'd2, 8'd2);
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("t2_en[%0d]", i), 32'(dif.en), 32'(en_t2[i]));
      check_eq($sformatf("t2_data[%0d]", i), 32'(dif.data), 32'(data_t2[i]));
      if (i >= 2) check_eq($sformatf("t2_dout[%0d]", i), 32'(dif.data_out), 32'(dout_t2[i]));
      if (i < 10) tick();
    end
    check_eq("t2_done", 32'(done), 32'h1);
    check_eq("t2_busy", 32'(busy), 32'h0);
    check_eq("t2_err_count", 32'(err_count), 32'h0);
    check_eq("t2_beats", 32'(beats), 32'd8);

    // 3: back-to-back bursts, en high for 9 consecutive cycles
    kick(8'd3, 8'd0, 8'd3);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t3_en[%0d]", i), 32'(dif.en), (i < 9) ? 32'h1 : 32'h0);
      check_eq($sformatf("t3_busy[%0d]", i), 32'(busy), (i < 9) ? 32'h1 : 32'h0);
      if (i < 9) tick();
    end
    check_eq("t3_done", 32'(done), 32'h1);
    check_eq("t3_data", 32'(dif.data), 32'hB);
    check_eq("t3_beats", 32'(beats), 32'd17);
    check_eq("t3_err_count", 32'(err_count), 32'h0);

    // 4: corrupt data_out for three checked cycles
    fault = 1'b1;
    tick();
    tick();
    tick();
    fault = 1'b0;
    check_eq("t4_err", 32'(err), 32'h1);
    check_eq("t4_err_count", 32'(err_count), 32'd3);
    tick();
    tick();
    tick();
    check_eq("t4_err_sticky", 32'(err), 32'h1);
    check_eq("t4_err_count_hold", 32'(err_count), 32'd3);

    // 5a: zero bursts completes at once
    kick(8'd4, 8'd2, 8'd0);
    check_eq("t5a_done", 32'(done), 32'h1);
    check_eq("t5a_busy", 32'(busy), 32'h0);
    check_eq("t5a_en", 32'(dif.en), 32'h0);
    tick();
    tick();
    check_eq("t5a_en_later", 32'(dif.en), 32'h0);
    check_eq("t5a_beats", 32'(beats), 32'd17);

    // 5b: burst_len 0 gives one beat per burst
    kick(8'd0, 8'd1, 8'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5b_en[%0d]", i), 32'(dif.en), 32'(en_t5b[i]));
      if (i < 3) tick();
    end
    check_eq("t5b_done", 32'(done), 32'h1);
    check_eq("t5b_beats", 32'(beats), 32'd19);
    check_eq("t5b_data", 32'(dif.data), 32'hD);

    // 5c: start while busy is ignored
    kick(8'd2, 8'd1, 8'd2);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t5c_en[%0d]", i), 32'(dif.en), 32'(en_t5c[i]));
      if (i == 1) begin
        burst_len  = 8'd5;
        gap_len    = 8'd0;
        num_bursts = 8'd5;
        start      = 1'b1;
      end
      if (i < 5) tick();
      start = 1'b0;
    end
    check_eq("t5c_done", 32'(done), 32'h1);
    check_eq("t5c_beats", 32'(beats), 32'd23);
    check_eq("t5c_err_count", 32'(err_count), 32'd3);

    // 6: reset mid-burst, with a simultaneous start
    kick(8'd4, 8'd0, 8'd1);
    tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check_eq("t6_en", 32'(dif.en), 32'h0);
    check_eq("t6_data", 32'(dif.data), 32'hA);
    check_eq("t6_done", 32'(done), 32'h0);
    check_eq("t6_busy", 32'(busy), 32'h0);
    check_eq("t6_beats", 32'(beats), 32'h0);
    check_eq("t6_err", 32'(err), 32'h0);
    check_eq("t6_err_count", 32'(err_count), 32'h0);
    check_eq("t6_fill", 32'(u_dut.u_shadow.fill_q), 32'h0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    kick(8'd4, 8'd0, 8'd1);
    check_eq("t6_en_after", 32'(dif.en), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t6_done_after", 32'(done), 32'h1);
    check_eq("t6_err_after", 32'(err), 32'h0);
    check_eq("t6_err_count_after", 32'(err_count), 32'h0);
    check_eq("t6_beats_after", 32'(beats), 32'd4);
    check_eq("t6_data_after", 32'(dif.data), 32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
